muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Sequences the iterative divider and the multiplier for the EX stage, and owns the architectural HI/LO registers.
- Accepts DIV/DIVU/MULT/MULTU from EX and holds `div_complete` while the operation is in flight.
- Commits results to HI/LO when the operation finishes.
- Lets the WB stage write HI/LO for MTHI/MTLO, and cancels any in-flight operation on an exception flush.

Parameters:
- DIV_ITERS, 32, number of restoring-division iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  EX holds a valid multiply/divide instruction (valid & div_op); held high until ex_advance.
- req_op  in  2  00 DIV, 01 DIVU, 10 MULT, 11 MULTU.
- vsrc1  in  32  dividend / multiplicand (rs).
- vsrc2  in  32  divisor / multiplier (rt).
- ex_advance  in  1  EX instruction leaves the stage this cycle (valid_out & allow_out).
- flush  in  1  exception/ERET flush; cancels in-flight work.
- wb_hi_we  in  1  MTHI write from WB.
- wb_lo_we  in  1  MTLO write from WB.
- wb_wdata  in  32  MTHI/MTLO data.
- div_complete  out  1  result committed; EX may advance.
- busy  out  1  state != IDLE.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset values: state=IDLE, hi=0, lo=0, div_complete=0, busy=0, iteration counter=0.
- States:
  - IDLE: if req_valid & !flush, capture op and operands. DIV/DIVU go to DIV; MULT/MULTU go to MUL.
  - DIV: one iteration per cycle. On the cycle with count==DIV_ITERS-1, apply the sign fix, write HI=remainder and LO=quotient, and go to DONE.
  - MUL: single cycle. Compute the 64-bit product (signed for MULT, unsigned for MULTU), write HI=product[63:32] and LO=product[31:0], and go to DONE.
  - DONE: div_complete=1. Go to IDLE on ex_advance or flush; otherwise stay. No re-accept while in DONE.
- Latency:
  - Request first seen in cycle 0.
  - DIV/DIVU: div_complete=1 from cycle 33.
  - MULT/MULTU: div_complete=1 from cycle 2.
- Operand capture: operands are captured only at accept. Later changes on vsrc1/vsrc2 are ignored.
- Signed divide:
  - Divide |a| by |b| (unsigned).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (both DIV and DIVU): LO=0xFFFFFFFF, HI=vsrc1 as captured. This is forced deterministically.
- Flush:
  - flush has priority over every other event.
  - In DIV/MUL: go to IDLE next cycle; no HI/LO write; div_complete stays 0.
  - A flush in the same cycle as the final iteration or the MUL cycle suppresses the commit.
  - A flush in IDLE with req_valid blocks the accept.
- HI/LO write priority:
  - A commit from DIV/MUL beats a same-cycle wb_hi_we/wb_lo_we, because the EX instruction is younger.
  - Otherwise wb_hi_we writes hi and wb_lo_we writes lo, independently.
- Reset mid-operation: return to IDLE, clear hi/lo, drop div_complete.

Decomposition:
- Shared package:
  - op encodings: OP_DIV, OP_DIVU, OP_MULT, OP_MULTU.
  - state encoding: IDLE, DIV, MUL, DONE.
  - DIV_ITERS constant.
- Sub-module div_iter: restoring divider datapath.
  - 64-bit remainder/quotient shift register.
  - Load, step and sign-fix controls.
  - Driven by the muldiv_ctrl FSM and counter.

Test Plan:
- DIVU 100/7 (req held, ex_advance in first complete cycle) -> div_complete first high in cycle 33; LO=14, HI=2; IDLE next cycle.
- DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. Then DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- MULT 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=1, LO=0xFFFFFFFE; div_complete first high in cycle 2.
- DIVU 100/7 with flush in cycle 20 -> IDLE in cycle 21; HI/LO unchanged; div_complete never high. A new DIVU is accepted the next cycle and completes in 33 cycles.
- DONE with ex_advance low for 5 cycles:
  - div_complete held; vsrc changes have no effect; no second operation starts.
  - wb_lo_we=1 with wb_wdata=0xAAAA in the commit cycle -> LO takes the divide result, not 0xAAAA.
  - wb_hi_we alone in IDLE -> HI=wb_wdata next cycle.
- Reset asserted mid-DIV (cycle 10) -> hi=lo=0, busy=0, div_complete=0 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and constants for the multiply/divide controller.
package muldiv_ctrl_pkg;

    // Multiply/divide opcodes as presented by the EX stage.
    typedef enum logic [1:0] {
        OP_DIV   = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_MULTU = 2'b11
    } op_t;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One quotient bit per iteration.
    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX/WB-facing request, write-back and HI/LO result bundle.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic        req_valid;
    op_t         req_op;
    logic [31:0] vsrc1;
    logic [31:0] vsrc2;
    logic        ex_advance;
    logic        flush;
    logic        wb_hi_we;
    logic        wb_lo_we;
    logic [31:0] wb_wdata;
    logic        div_complete;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues requests and MTHI/MTLO writes.
    modport master (
        output req_valid, req_op, vsrc1, vsrc2, ex_advance, flush,
               wb_hi_we, wb_lo_we, wb_wdata,
        input  div_complete, busy, hi, lo
    );

    // Controller side.
    modport slave (
        input  req_valid, req_op, vsrc1, vsrc2, ex_advance, flush,
               wb_hi_we, wb_lo_we, wb_wdata,
        output div_complete, busy, hi, lo
    );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: works on magnitudes, one quotient bit per step.
// Outputs show the sign-corrected result of the step taken this cycle, so the
// controller can commit on the final iteration without an extra cycle.
module muldiv_ctrl_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    // work_reg = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [63:0] work_reg;
    logic [31:0] divisor_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] partial;
    logic [31:0] sub;
    logic        fits;
    logic [63:0] work_next;

    // Operand magnitudes and one restoring step.
    always_comb begin
        a_neg     = is_signed & dividend[31];
        b_neg     = is_signed & divisor[31];
        abs_a     = a_neg ? -dividend : dividend;
        abs_b     = b_neg ? -divisor : divisor;
        partial   = work_reg[63:31];
        // When the trial subtraction fits, the true difference is below 2^32,
        // so the low 32 bits are exact.
        sub       = partial[31:0] - divisor_reg;
        fits      = partial >= {1'b0, divisor_reg};
        work_next = {(fits ? sub : partial[31:0]), work_reg[30:0], fits};
        quotient  = neg_q_reg ? -work_next[31:0] : work_next[31:0];
        remainder = neg_r_reg ? -work_next[63:32] : work_next[63:32];
    end

    // Load magnitudes and signs at accept, then shift one bit per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_reg    <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
        end else if (load) begin
            work_reg    <= {32'd0, abs_a};
            divisor_reg <= abs_b;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
        end else if (step) begin
            work_reg    <= work_next;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for EX; owns HI/LO and arbitrates MTHI/MTLO writes.
module muldiv_ctrl #(
    parameter int DIV_ITERS = muldiv_ctrl_pkg::DIV_ITERS
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_ctrl_if.slave   bus
);
    import muldiv_ctrl_pkg::*;

    localparam int CNT_W = $clog2(DIV_ITERS);

    state_t             state_reg;
    op_t                op_reg;
    logic [31:0]        op_a_reg;
    logic [31:0]        op_b_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;
    logic               div_complete_reg;
    logic               busy_reg;

    logic               accept;
    logic               req_is_div;
    logic               div_load;
    logic               div_step;
    logic [31:0]        iter_q;
    logic [31:0]        iter_r;
    logic [31:0]        div_hi;
    logic [31:0]        div_lo;
    logic               mul_signed;
    logic [63:0]        ext_a;
    logic [63:0]        ext_b;
    logic [63:0]        product;

    // Accept decode, divide-by-zero override and the single-cycle product.
    always_comb begin
        req_is_div = (bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU);
        accept     = (state_reg == IDLE) && bus.req_valid && !bus.flush;
        div_load   = accept && req_is_div;
        div_step   = (state_reg == DIV);
        div_lo     = (op_b_reg == 32'd0) ? 32'hFFFF_FFFF : iter_q;
        div_hi     = (op_b_reg == 32'd0) ? op_a_reg : iter_r;
        mul_signed = (op_reg == OP_MULT);
        ext_a      = {{32{mul_signed & op_a_reg[31]}}, op_a_reg};
        ext_b      = {{32{mul_signed & op_b_reg[31]}}, op_b_reg};
        product    = ext_a * ext_b;
    end

    muldiv_ctrl_div_iter u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .is_signed (bus.req_op == OP_DIV),
        .dividend  (bus.vsrc1),
        .divisor   (bus.vsrc2),
        .quotient  (iter_q),
        .remainder (iter_r)
    );

    // Control FSM plus HI/LO; a commit is written after the WB writes so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            op_reg           <= OP_DIV;
            op_a_reg         <= '0;
            op_b_reg         <= '0;
            count_reg        <= '0;
            hi_reg           <= '0;
            lo_reg           <= '0;
            div_complete_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            if (bus.wb_hi_we) hi_reg <= bus.wb_wdata;
            if (bus.wb_lo_we) lo_reg <= bus.wb_wdata;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= bus.req_op;
                        op_a_reg  <= bus.vsrc1;
                        op_b_reg  <= bus.vsrc2;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= req_is_div ? DIV : MUL;
                    end
                end
                DIV: begin
                    if (bus.flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (count_reg == CNT_W'(DIV_ITERS - 1)) begin
                        hi_reg           <= div_hi;
                        lo_reg           <= div_lo;
                        div_complete_reg <= 1'b1;
                        state_reg        <= DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                MUL: begin
                    if (bus.flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        hi_reg           <= product[63:32];
                        lo_reg           <= product[31:0];
                        div_complete_reg <= 1'b1;
                        state_reg        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.flush || bus.ex_advance) begin
                        div_complete_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.div_complete = div_complete_reg;
    assign bus.busy         = busy_reg;
    assign bus.hi           = hi_reg;
    assign bus.lo           = lo_reg;

endmodule
